// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
//   i_read_m    : read request, held high until the read completes
//   i_address   : read address, stable for as long as i_read_m is high
//   i_data      : read data, meaningful only in the input_ready cycle
//   input_ready : one-cycle completion pulse from memory
// Handshake: a read is outstanding from the first cycle i_read_m=1 until the
// cycle input_ready=1 (inclusive); the address is held throughout, and
// input_ready seen while i_read_m=0 carries no meaning.
interface fetch_unit_if #(
  parameter int WORD_SIZE = 16
) ();
  logic                 i_read_m;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;
  logic                 input_ready;

  modport master (
    output i_read_m,
    output i_address,
    input  i_data,
    input  input_ready
  );

  modport slave (
    input  i_read_m,
    input  i_address,
    output i_data,
    output input_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Owns the PC, issues reads to instruction
// memory over `bus`, and buffers returned words in a small FIFO so memory
// latency and ID stalls are decoupled. A redirect flushes the FIFO and
// squashes any read still in flight.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   bus           : instruction memory read bus (master side)
//   stall         : ID cannot accept the head entry this cycle
//   redirect      : flush and restart fetch at redirect_pc
//   redirect_pc   : new fetch PC
//   inst          : head instruction (0 when inst_valid=0)
//   inst_pc       : PC of inst (0 when inst_valid=0)
//   inst_npc      : inst_pc + 1
//   inst_valid    : head entry valid; it is consumed when stall=0
//   num_fetched   : count of instructions handed to ID (wraps)
//   state_dbg     : current FSM state (0=IDLE, 1=REQ)
module fetch_unit #(
  parameter int                   WORD_SIZE  = 16,
  parameter int                   FIFO_DEPTH = 2,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_unit_if.master         bus,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic [WORD_SIZE-1:0] inst,
  output logic [WORD_SIZE-1:0] inst_pc,
  output logic [WORD_SIZE-1:0] inst_npc,
  output logic                 inst_valid,
  output logic [WORD_SIZE-1:0] num_fetched,
  output logic                 state_dbg
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] pc;      // next PC to fetch
  logic [WORD_SIZE-1:0] addr;    // address on the bus; equals pc unless squashing
  logic                 squash;  // in-flight read belongs to a redirected-away path
  logic [CNT_W-1:0]     count, count_nxt;
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [WORD_SIZE-1:0] fifo_inst [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] fifo_pc   [FIFO_DEPTH];

  logic done, push, pop, credit;

  assign done = (state == REQ) && bus.input_ready;
  assign push = done && !squash && !redirect;
  assign pop  = (count != '0) && !stall && !redirect;

  always_comb begin
    count_nxt = count;
    if (redirect) count_nxt = '0;
    else          count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  // A new read may start only if a FIFO slot is guaranteed for its data,
  // so a read in flight can never overflow the queue.
  assign credit = count_nxt < CNT_W'(FIFO_DEPTH);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!redirect && credit) state_nxt = REQ;
      REQ:  if (done) state_nxt = credit ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // PC / bus address / squash tracking. During a squash the bus address is
  // frozen on the abandoned read while pc already holds the redirect target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      addr   <= RESET_PC;
      squash <= 1'b0;
    end else if (redirect) begin
      pc <= redirect_pc;
      if ((state == REQ) && !bus.input_ready) begin
        squash <= 1'b1;
      end else begin
        squash <= 1'b0;
        addr   <= redirect_pc;
      end
    end else if (done) begin
      if (squash) begin
        squash <= 1'b0;
        addr   <= pc;
      end else begin
        pc   <= pc + 1'b1;
        addr <= pc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      num_fetched <= '0;
    end else begin
      count <= count_nxt;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) num_fetched <= num_fetched + 1'b1;
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= bus.i_data;
      fifo_pc[wr_ptr]   <= addr;
    end
  end

  assign bus.i_read_m  = (state == REQ);
  assign bus.i_address = addr;
  assign inst_valid    = (count != '0);
  assign inst          = inst_valid ? fifo_inst[rd_ptr] : '0;
  assign inst_pc       = inst_valid ? fifo_pc[rd_ptr] : '0;
  assign inst_npc      = inst_pc + 1'b1;
  assign state_dbg     = state;
endmodule
